portal_access_arbiter: RTL and testbench
========================================

# portal_access_arbiter

Arbitrates AXI-style read and write bursts onto the single shared portal register-access port and emits the matching read-data and write-response beats. Sits between the portal's AR/AW/W request FIFOs and the control/user register file. Only one burst owns the register port at a time. Grants alternate round-robin at burst granularity.

## Interface

- ADDR_WIDTH, 5, register byte-address width; beat address wraps modulo 2^ADDR_WIDTH
- DATA_WIDTH, 32, register data width
- ID_WIDTH, 6, transaction id width
- LEN_WIDTH, 4, burst length field; beats = len + 1

Clocking: one clock, CLK. Reset RST is synchronous and active-high.

- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- rreq$enq__ENA / rreq$enq__RDY  in / out  1 / 1  read burst request handshake
- rreq$enq$addr, rreq$enq$len, rreq$enq$id  in  ADDR_WIDTH, LEN_WIDTH, ID_WIDTH  read burst start address, length, id
- wreq$enq__ENA / wreq$enq__RDY  in / out  1 / 1  write burst request handshake
- wreq$enq$addr, wreq$enq$len, wreq$enq$id  in  ADDR_WIDTH, LEN_WIDTH, ID_WIDTH  write burst start address, length, id
- wdata$enq__ENA / wdata$enq__RDY  in / out  1 / 1  write data beat handshake
- wdata$enq$data  in  DATA_WIDTH  write data beat
- reg$access__ENA  out  1  register access strobe
- reg$access__RDY  in  1  register port can accept an access
- reg$access$write  out  1  1 = write, 0 = read
- reg$access$addr  out  ADDR_WIDTH  beat byte address
- reg$access$wdata  out  DATA_WIDTH  write data
- reg$rdata  in  DATA_WIDTH  read data, valid exactly one cycle after a read access fires
- rresp$enq__ENA / rresp$enq__RDY  out / in  1 / 1  read response beat handshake
- rresp$enq$data, rresp$enq$id, rresp$enq$last  out  DATA_WIDTH, ID_WIDTH, 1  read response beat data, id, last-beat flag
- bresp$enq__ENA / bresp$enq__RDY  out / in  1 / 1  write response handshake
- bresp$enq$id  out  ID_WIDTH  write response id

## Operation

- A handshake fires when __ENA and __RDY are both high in the same cycle.
- Request holding registers: rhold and whold, one entry each.
  - rreq$enq__RDY = !rhold_valid; wreq$enq__RDY = !whold_valid.
  - A holding register clears when its burst is granted, so the next request can queue during the current burst.
- wbuf: one-entry write data buffer.
  - wdata$enq__RDY = !wbuf_valid | (write access fires this cycle).
  - Write data may arrive before its wreq.
- States: IDLE, RBURST, WBURST, WRESP.
- IDLE: arbitration.
  - Only rhold valid: grant read.
  - Only whold valid: grant write.
  - Both valid: grant the side opposite last_grant.
  - On grant: copy addr, len and id into the working registers cur_addr, beats_left = len, cur_id. Set last_grant. Go to RBURST or WBURST.
  - No access is issued in the grant cycle.
- RBURST:
  - Issue a read access when !inflight & (!rbuf_valid | rresp fires this cycle) & reg$access__RDY. Set inflight.
  - On the next cycle, capture reg$rdata into rbuf with cur_id and last = (beat was final). Clear inflight.
  - After each issue: cur_addr += 4, truncated to ADDR_WIDTH; beats_left -= 1.
  - Exit to IDLE in the cycle the final beat's rresp fires.
- WBURST:
  - Issue a write access when wbuf_valid & reg$access__RDY. Consumes wbuf; same address and count update as RBURST.
  - After the final beat's access fires, go to WRESP.
- WRESP: bresp$enq__ENA = 1 with cur_id. Go to IDLE when bresp fires.
- rresp$enq__ENA = rbuf_valid. rresp$enq$data, $id and $last come from rbuf.
- reg$access__ENA is only asserted together with __RDY, so every assertion is an access.
- Responses are never dropped or reordered. Read beats return in address order.

## Timing

- Reset values:
  - state = IDLE; last_grant = write, so a read wins the first tie.
  - All valid and inflight flags cleared.
  - All __ENA outputs 0; all data outputs 0.
  - rreq, wreq and wdata __RDY = 1 in the first cycle after reset.
- Reset mid-burst: the burst is abandoned, no further responses are emitted, and buffered data is discarded.
- Request latency: request fires at t; holding register valid at t+1; grant at t+1 (if IDLE); first access at t+2 at the earliest.
- Read: access at t; reg$rdata sampled at t+1; rresp$enq__ENA from t+2. Maximum throughput is 1 read beat per 2 cycles.
- Write: 1 beat per cycle when wdata streams and reg$access__RDY = 1.
- bresp$enq__ENA rises the cycle after the final write access.
- Idle gap: at least 1 IDLE cycle between bursts.
- len = max (15) gives 16 beats. The address wraps: for example 5'd28 + 4 = 5'd0.
- Simultaneous rreq and wreq arriving in the same cycle from reset: read is granted first, write next.
- A request arriving during a burst waits in its holding register. A second request on the same side stalls (__RDY = 0).

## Test plan

- Single read, addr 8, len 0, id 5: one read access at addr 8 → rresp data = reg$rdata, id 5, last 1 → IDLE.
- Write burst, addr 24, len 3, id 2, wdata 1..4 streamed:
  - Writes at 24, 28, 0, 4 with data 1..4 on consecutive cycles.
  - bresp id 2 one cycle after the 4th access.
- rreq and wreq in the same cycle after reset, then both repeated twice: grant order read, write, read, write.
- Read len 15 with rresp$enq__RDY held low for 10 cycles mid-burst:
  - No further access issued while rbuf is full.
  - All 16 beats delivered in order; last only on beat 16.
- Write with reg$access__RDY toggling and wdata arriving 3 cycles before wreq: data held in wbuf and all beats written correctly.
- RST asserted mid read burst (beat 3 of 8): next cycle all __ENA outputs = 0, state IDLE; a new read then completes normally.

Source files
------------

// File: rtl/portal_access_arbiter.sv
// portal_access_arbiter: round-robin arbiter placing read/write bursts onto the shared register port
module portal_access_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 6,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rreq_ena,
  output logic                  o_rreq_rdy,
  input  logic [ADDR_WIDTH-1:0] i_rreq_addr,
  input  logic [LEN_WIDTH-1:0]  i_rreq_len,
  input  logic [ID_WIDTH-1:0]   i_rreq_id,
  input  logic                  i_wreq_ena,
  output logic                  o_wreq_rdy,
  input  logic [ADDR_WIDTH-1:0] i_wreq_addr,
  input  logic [LEN_WIDTH-1:0]  i_wreq_len,
  input  logic [ID_WIDTH-1:0]   i_wreq_id,
  input  logic                  i_wdata_ena,
  output logic                  o_wdata_rdy,
  input  logic [DATA_WIDTH-1:0] i_wdata_data,
  output logic                  o_reg_ena,
  input  logic                  i_reg_rdy,
  output logic                  o_reg_write,
  output logic [ADDR_WIDTH-1:0] o_reg_addr,
  output logic [DATA_WIDTH-1:0] o_reg_wdata,
  input  logic [DATA_WIDTH-1:0] i_reg_rdata,
  output logic                  o_rresp_ena,
  input  logic                  i_rresp_rdy,
  output logic [DATA_WIDTH-1:0] o_rresp_data,
  output logic [ID_WIDTH-1:0]   o_rresp_id,
  output logic                  o_rresp_last,
  output logic                  o_bresp_ena,
  input  logic                  i_bresp_rdy,
  output logic [ID_WIDTH-1:0]   o_bresp_id
);
  typedef enum logic [1:0] {IDLE, RBURST, WBURST, WRESP} state_t;
  state_t r_state, w_next;
  logic r_last_grant;
  logic r_rhold_valid, r_whold_valid;
  logic [ADDR_WIDTH-1:0] r_rhold_addr, r_whold_addr, r_cur_addr;
  logic [LEN_WIDTH-1:0] r_rhold_len, r_whold_len, r_beats_left;
  logic [ID_WIDTH-1:0] r_rhold_id, r_whold_id, r_cur_id, r_rbuf_id;
  logic r_wbuf_valid;
  logic [DATA_WIDTH-1:0] r_wbuf_data, r_rbuf_data;
  logic r_all_issued, r_inflight, r_inflight_last;
  logic r_rbuf_valid, r_rbuf_last;
  logic w_rreq_fire, w_wreq_fire, w_wdata_fire, w_rresp_fire;
  logic w_grant_r, w_grant_w, w_rd_issue, w_wr_issue, w_final;
  assign w_final      = r_beats_left == '0;
  assign w_rreq_fire  = i_rreq_ena & o_rreq_rdy;
  assign w_wreq_fire  = i_wreq_ena & o_wreq_rdy;
  assign w_wdata_fire = i_wdata_ena & o_wdata_rdy;
  assign w_rresp_fire = o_rresp_ena & i_rresp_rdy;
  // r_last_grant = 1 means the previous burst was a write, so a read wins the next tie
  assign w_grant_r = (r_state == IDLE) & r_rhold_valid & (!r_whold_valid | r_last_grant);
  assign w_grant_w = (r_state == IDLE) & r_whold_valid & (!r_rhold_valid | !r_last_grant);
  assign w_rd_issue = (r_state == RBURST) & !r_all_issued & !r_inflight &
                      (!r_rbuf_valid | w_rresp_fire) & i_reg_rdy;
  assign w_wr_issue = (r_state == WBURST) & r_wbuf_valid & i_reg_rdy;
  assign o_rreq_rdy   = !r_rhold_valid;
  assign o_wreq_rdy   = !r_whold_valid;
  assign o_wdata_rdy  = !r_wbuf_valid | w_wr_issue;
  assign o_reg_ena    = w_rd_issue | w_wr_issue;
  assign o_reg_write  = r_state == WBURST;
  assign o_reg_addr   = r_cur_addr;
  assign o_reg_wdata  = r_wbuf_data;
  assign o_rresp_ena  = r_rbuf_valid;
  assign o_rresp_data = r_rbuf_data;
  assign o_rresp_id   = r_rbuf_id;
  assign o_rresp_last = r_rbuf_last;
  assign o_bresp_ena  = r_state == WRESP;
  assign o_bresp_id   = r_cur_id;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_grant_r ? RBURST : w_grant_w ? WBURST : IDLE;
      RBURST:  w_next = (w_rresp_fire & r_rbuf_last) ? IDLE : RBURST;
      WBURST:  w_next = (w_wr_issue & w_final) ? WRESP : WBURST;
      WRESP:   w_next = i_bresp_rdy ? IDLE : WRESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant    <= 1'b1;
      r_rhold_valid   <= 1'b0;
      r_whold_valid   <= 1'b0;
      r_rhold_addr    <= '0;
      r_rhold_len     <= '0;
      r_rhold_id      <= '0;
      r_whold_addr    <= '0;
      r_whold_len     <= '0;
      r_whold_id      <= '0;
      r_wbuf_valid    <= 1'b0;
      r_wbuf_data     <= '0;
      r_cur_addr      <= '0;
      r_beats_left    <= '0;
      r_cur_id        <= '0;
      r_all_issued    <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_rbuf_valid    <= 1'b0;
      r_rbuf_data     <= '0;
      r_rbuf_id       <= '0;
      r_rbuf_last     <= 1'b0;
    end else begin
      if (w_rreq_fire) begin
        r_rhold_valid <= 1'b1;
        r_rhold_addr  <= i_rreq_addr;
        r_rhold_len   <= i_rreq_len;
        r_rhold_id    <= i_rreq_id;
      end else if (w_grant_r) r_rhold_valid <= 1'b0;
      if (w_wreq_fire) begin
        r_whold_valid <= 1'b1;
        r_whold_addr  <= i_wreq_addr;
        r_whold_len   <= i_wreq_len;
        r_whold_id    <= i_wreq_id;
      end else if (w_grant_w) r_whold_valid <= 1'b0;
      if (w_wdata_fire) begin
        r_wbuf_valid <= 1'b1;
        r_wbuf_data  <= i_wdata_data;
      end else if (w_wr_issue) r_wbuf_valid <= 1'b0;
      if (w_grant_r | w_grant_w) begin
        r_last_grant <= w_grant_w;
        r_cur_addr   <= w_grant_r ? r_rhold_addr : r_whold_addr;
        r_beats_left <= w_grant_r ? r_rhold_len : r_whold_len;
        r_cur_id     <= w_grant_r ? r_rhold_id : r_whold_id;
        r_all_issued <= 1'b0;
      end else if (w_rd_issue | w_wr_issue) begin
        r_cur_addr   <= r_cur_addr + ADDR_WIDTH'(4);
        r_beats_left <= r_beats_left - LEN_WIDTH'(1);
        r_all_issued <= w_final;
      end
      r_inflight      <= w_rd_issue;
      r_inflight_last <= w_rd_issue & w_final;
      // register read data is only valid the cycle after the access
      if (r_inflight) begin
        r_rbuf_valid <= 1'b1;
        r_rbuf_data  <= i_reg_rdata;
        r_rbuf_id    <= r_cur_id;
        r_rbuf_last  <= r_inflight_last;
      end else if (w_rresp_fire) r_rbuf_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_portal_access_arbiter.sv
// tb_portal_access_arbiter: scoreboard bench for the portal burst arbiter
module tb_portal_access_arbiter;
  localparam int AW = 5, DW = 32, IW = 6, LW = 4;
  logic clk = 0, rst = 1;
  logic i_rreq_ena = 0, i_wreq_ena = 0, i_wdata_ena = 0;
  logic [AW-1:0] i_rreq_addr = '0, i_wreq_addr = '0;
  logic [LW-1:0] i_rreq_len = '0, i_wreq_len = '0;
  logic [IW-1:0] i_rreq_id = '0, i_wreq_id = '0;
  logic [DW-1:0] i_wdata_data = '0, i_reg_rdata = '0;
  logic i_reg_rdy = 1, i_rresp_rdy = 1, i_bresp_rdy = 1;
  logic o_rreq_rdy, o_wreq_rdy, o_wdata_rdy, o_reg_ena, o_reg_write;
  logic [AW-1:0] o_reg_addr;
  logic [DW-1:0] o_reg_wdata, o_rresp_data;
  logic o_rresp_ena, o_rresp_last, o_bresp_ena;
  logic [IW-1:0] o_rresp_id, o_bresp_id;

  portal_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_rreq_ena(i_rreq_ena), .o_rreq_rdy(o_rreq_rdy), .i_rreq_addr(i_rreq_addr),
    .i_rreq_len(i_rreq_len), .i_rreq_id(i_rreq_id),
    .i_wreq_ena(i_wreq_ena), .o_wreq_rdy(o_wreq_rdy), .i_wreq_addr(i_wreq_addr),
    .i_wreq_len(i_wreq_len), .i_wreq_id(i_wreq_id),
    .i_wdata_ena(i_wdata_ena), .o_wdata_rdy(o_wdata_rdy), .i_wdata_data(i_wdata_data),
    .o_reg_ena(o_reg_ena), .i_reg_rdy(i_reg_rdy), .o_reg_write(o_reg_write),
    .o_reg_addr(o_reg_addr), .o_reg_wdata(o_reg_wdata), .i_reg_rdata(i_reg_rdata),
    .o_rresp_ena(o_rresp_ena), .i_rresp_rdy(i_rresp_rdy), .o_rresp_data(o_rresp_data),
    .o_rresp_id(o_rresp_id), .o_rresp_last(o_rresp_last),
    .o_bresp_ena(o_bresp_ena), .i_bresp_rdy(i_bresp_rdy), .o_bresp_id(o_bresp_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} acc_t;
  typedef struct packed {logic [DW-1:0] d; logic [IW-1:0] id; logic last;} rsp_t;
  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  logic [IW-1:0] exp_b[$];
  logic [DW-1:0] wdq[$];
  int acc_cyc[$];
  int n_chk = 0, n_fail = 0, cyc = 0, n_acc = 0, rresp_cyc = 0, bresp_cyc = 0;
  logic tog_en = 0;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return 32'h5A00_0000 | (32'(a) << 12) | (32'(a) * 32'h13);
  endfunction

  // register file model: read data appears exactly one cycle after a read access
  always @(posedge clk) begin
    cyc <= cyc + 1;
    i_reg_rdata <= (o_reg_ena && !o_reg_write) ? rd_val(o_reg_addr) : 32'hDEAD_BEEF;
  end

  initial forever begin
    @(posedge clk); #1;
    i_wdata_ena = !rst && wdq.size() > 0;
    i_wdata_data = (wdq.size() > 0) ? wdq[0] : '0;
    @(negedge clk);
    if (!rst && i_wdata_ena && o_wdata_rdy) void'(wdq.pop_front());
  end

  initial forever begin
    @(posedge clk); #1;
    i_reg_rdy = tog_en ? ~i_reg_rdy : 1'b1;
  end

  initial begin : monitor
    acc_t e;
    rsp_t r;
    logic [IW-1:0] b;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (o_reg_ena) begin
          n_acc++;
          acc_cyc.push_back(cyc);
          n_chk++;
          if (i_reg_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL acc_strobe: ena=1 with rdy=%b, required rdy=1", i_reg_rdy);
          end
          n_chk++;
          if (exp_acc.size() == 0) begin
            n_fail++;
            $display("FAIL acc_unexpected: write=%b addr=%0d, required no access", o_reg_write, o_reg_addr);
          end else begin
            e = exp_acc.pop_front();
            if (o_reg_write !== e.w || o_reg_addr !== e.a || (e.w && o_reg_wdata !== e.d)) begin
              n_fail++;
              $display("FAIL acc: got w=%b a=%0d d=%h, required w=%b a=%0d d=%h",
                       o_reg_write, o_reg_addr, o_reg_wdata, e.w, e.a, e.d);
            end
          end
        end
        if (o_rresp_ena && i_rresp_rdy) begin
          rresp_cyc = cyc;
          n_chk++;
          if (exp_rsp.size() == 0) begin
            n_fail++;
            $display("FAIL rresp_unexpected: data=%h id=%0d", o_rresp_data, o_rresp_id);
          end else begin
            r = exp_rsp.pop_front();
            if ({o_rresp_data, o_rresp_id, o_rresp_last} !== r) begin
              n_fail++;
              $display("FAIL rresp: got d=%h id=%0d last=%b, required d=%h id=%0d last=%b",
                       o_rresp_data, o_rresp_id, o_rresp_last, r.d, r.id, r.last);
            end
          end
        end
        if (o_bresp_ena && i_bresp_rdy) begin
          bresp_cyc = cyc;
          n_chk++;
          if (exp_b.size() == 0) begin
            n_fail++;
            $display("FAIL bresp_unexpected: id=%0d", o_bresp_id);
          end else begin
            b = exp_b.pop_front();
            if (o_bresp_id !== b) begin
              n_fail++;
              $display("FAIL bresp: got id=%0d, required id=%0d", o_bresp_id, b);
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_read(input logic [AW-1:0] a, input int len, input logic [IW-1:0] id);
    logic [AW-1:0] ad = a;
    for (int i = 0; i <= len; i++) begin
      exp_acc.push_back('{1'b0, ad, '0});
      exp_rsp.push_back('{rd_val(ad), id, i == len});
      ad = ad + 5'd4;
    end
  endtask

  task automatic push_write(input logic [AW-1:0] a, input int len, input logic [IW-1:0] id,
                            input logic [DW-1:0] base);
    logic [AW-1:0] ad = a;
    for (int i = 0; i <= len; i++) begin
      exp_acc.push_back('{1'b1, ad, base + 32'(i)});
      wdq.push_back(base + 32'(i));
      ad = ad + 5'd4;
    end
    exp_b.push_back(id);
  endtask

  task automatic send_req(input bit is_w, input logic [AW-1:0] a, input int len,
                          input logic [IW-1:0] id, output int fc, output bit ok);
    ok = 0;
    fc = -1;
    if (is_w) begin
      i_wreq_ena = 1; i_wreq_addr = a; i_wreq_len = LW'(len); i_wreq_id = id;
    end else begin
      i_rreq_ena = 1; i_rreq_addr = a; i_rreq_len = LW'(len); i_rreq_id = id;
    end
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      if (is_w ? o_wreq_rdy : o_rreq_rdy) begin ok = 1; fc = cyc; end
      tick();
    end
    i_wreq_ena = 0;
    i_rreq_ena = 0;
  endtask

  task automatic send_both(input logic [AW-1:0] ra, input logic [IW-1:0] rid,
                           input logic [AW-1:0] wa, input logic [IW-1:0] wid,
                           output int rfc, output int wfc, output bit ok);
    bit rf = 0, wf = 0;
    rfc = -1; wfc = -1;
    i_rreq_ena = 1; i_rreq_addr = ra; i_rreq_len = 4'd1; i_rreq_id = rid;
    i_wreq_ena = 1; i_wreq_addr = wa; i_wreq_len = 4'd1; i_wreq_id = wid;
    for (int k = 0; k < 300 && !(rf && wf); k++) begin
      @(negedge clk);
      if (i_rreq_ena && o_rreq_rdy) begin rf = 1; rfc = cyc; end
      if (i_wreq_ena && o_wreq_rdy) begin wf = 1; wfc = cyc; end
      tick();
      if (rf) i_rreq_ena = 0;
      if (wf) i_wreq_ena = 0;
    end
    i_rreq_ena = 0;
    i_wreq_ena = 0;
    ok = rf && wf;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk); #1;
      if (exp_acc.size() == 0 && exp_rsp.size() == 0 && exp_b.size() == 0 && wdq.size() == 0) ok = 1;
    end
    tick();
    tick();
  endtask

  task automatic wait_acc(input int target, output bit ok);
    ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk); #1;
      if (n_acc >= target) ok = 1;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    n_chk++;
    if ({o_reg_ena, o_rresp_ena, o_bresp_ena} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_ena: got %b, required 000", {o_reg_ena, o_rresp_ena, o_bresp_ena});
    end
    n_chk++;
    if ({o_reg_write, o_reg_addr, o_reg_wdata, o_rresp_data, o_rresp_id, o_rresp_last, o_bresp_id} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%0d wdata=%h rdata=%h rid=%0d bid=%0d, required all 0",
               o_reg_addr, o_reg_wdata, o_rresp_data, o_rresp_id, o_bresp_id);
    end
    n_chk++;
    if ({o_rreq_rdy, o_wreq_rdy, o_wdata_rdy} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b, required 111", {o_rreq_rdy, o_wreq_rdy, o_wdata_rdy});
    end
    tick();
  endtask

  task automatic test_single_read();
    int fc;
    bit ok, dr;
    acc_cyc.delete();
    push_read(5'd8, 0, 6'd5);
    send_req(0, 5'd8, 0, 6'd5, fc, ok);
    wait_drain(dr);
    n_chk++;
    if (!(ok && dr)) begin
      n_fail++;
      $display("FAIL single_read_done: fired=%b drained=%b, required 1 1", ok, dr);
    end
    n_chk++;
    if (acc_cyc.size() != 1 || acc_cyc[0] != fc + 2) begin
      n_fail++;
      $display("FAIL single_read_latency: accesses=%0d first=%0d, required 1 at %0d",
               acc_cyc.size(), acc_cyc.size() ? acc_cyc[0] : -1, fc + 2);
    end
    n_chk++;
    if (acc_cyc.size() > 0 && rresp_cyc != acc_cyc[0] + 2) begin
      n_fail++;
      $display("FAIL single_read_rresp_time: got cycle %0d, required %0d", rresp_cyc, acc_cyc[0] + 2);
    end
  endtask

  task automatic test_write_burst();
    int fc;
    bit ok, dr, consec;
    acc_cyc.delete();
    push_write(5'd24, 3, 6'd2, 32'd1);
    send_req(1, 5'd24, 3, 6'd2, fc, ok);
    wait_drain(dr);
    n_chk++;
    if (!(ok && dr) || acc_cyc.size() != 4) begin
      n_fail++;
      $display("FAIL write_burst_done: fired=%b drained=%b accesses=%0d, required 1 1 4", ok, dr, acc_cyc.size());
    end else begin
      consec = 1;
      for (int k = 1; k < 4; k++) if (acc_cyc[k] != acc_cyc[0] + k) consec = 0;
      n_chk++;
      if (!consec || acc_cyc[0] != fc + 2) begin
        n_fail++;
        $display("FAIL write_burst_stream: cycles %0d %0d %0d %0d, required consecutive from %0d",
                 acc_cyc[0], acc_cyc[1], acc_cyc[2], acc_cyc[3], fc + 2);
      end
      n_chk++;
      if (bresp_cyc != acc_cyc[3] + 1) begin
        n_fail++;
        $display("FAIL write_bresp_time: got cycle %0d, required %0d", bresp_cyc, acc_cyc[3] + 1);
      end
    end
  endtask

  task automatic test_grant_order();
    int rfc, wfc;
    bit ok, dr;
    for (int p = 0; p < 3; p++) begin
      push_read(5'(8 * p), 1, 6'(10 + p));
      push_write(5'(12 + 4 * p), 1, 6'(20 + p), 32'(100 + 10 * p));
      send_both(5'(8 * p), 6'(10 + p), 5'(12 + 4 * p), 6'(20 + p), rfc, wfc, ok);
      n_chk++;
      if (!ok || (p == 0 && rfc != wfc)) begin
        n_fail++;
        $display("FAIL grant_order_req%0d: fired=%b rcyc=%0d wcyc=%0d", p, ok, rfc, wfc);
      end
    end
    wait_drain(dr);
    n_chk++;
    if (!dr) begin
      n_fail++;
      $display("FAIL grant_order_drain: pending acc=%0d rsp=%0d b=%0d, required 0",
               exp_acc.size(), exp_rsp.size(), exp_b.size());
    end
  endtask

  task automatic test_read_stall();
    int fc, base, a0;
    bit ok, hit, dr, held;
    base = n_acc;
    push_read(5'd4, 15, 6'd7);
    send_req(0, 5'd4, 15, 6'd7, fc, ok);
    wait_acc(base + 4, hit);
    i_rresp_rdy = 0;
    tick();
    tick();
    a0 = n_acc;
    held = 1;
    repeat (8) begin
      tick();
      @(negedge clk);
      if (o_rresp_ena !== 1'b1) held = 0;
    end
    n_chk++;
    if (n_acc != a0 || !held) begin
      n_fail++;
      $display("FAIL stall_no_issue: accesses during stall=%0d rresp_held=%b, required 0 1", n_acc - a0, held);
    end
    tick();
    i_rresp_rdy = 1;
    wait_drain(dr);
    n_chk++;
    if (!(ok && hit && dr) || n_acc - base != 16) begin
      n_fail++;
      $display("FAIL stall_burst: fired=%b drained=%b beats=%0d, required 1 1 16", ok, dr, n_acc - base);
    end
  endtask

  task automatic test_write_toggle();
    int fc;
    bit ok, dr;
    push_write(5'd8, 2, 6'd33, 32'hA0);
    repeat (3) tick();
    @(negedge clk);
    n_chk++;
    if (o_wdata_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL early_wdata_held: wdata_rdy=%b, required 0", o_wdata_rdy);
    end
    tick();
    tog_en = 1;
    send_req(1, 5'd8, 2, 6'd33, fc, ok);
    wait_drain(dr);
    tog_en = 0;
    tick();
    n_chk++;
    if (!(ok && dr)) begin
      n_fail++;
      $display("FAIL write_toggle_done: fired=%b drained=%b, required 1 1", ok, dr);
    end
  endtask

  task automatic test_reset_mid();
    int fc, base, a0;
    bit ok, hit, dr;
    base = n_acc;
    push_read(5'd0, 7, 6'd9);
    send_req(0, 5'd0, 7, 6'd9, fc, ok);
    wait_acc(base + 3, hit);
    rst = 1;
    exp_acc.delete();
    exp_rsp.delete();
    exp_b.delete();
    wdq.delete();
    tick();
    rst = 0;
    @(negedge clk);
    n_chk++;
    if (!(ok && hit) || {o_reg_ena, o_rresp_ena, o_bresp_ena} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_ena: got %b (reached beat3=%b), required 000",
               {o_reg_ena, o_rresp_ena, o_bresp_ena}, hit);
    end
    n_chk++;
    if ({o_rreq_rdy, o_wreq_rdy, o_wdata_rdy} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_mid_rdy: got %b, required 111", {o_rreq_rdy, o_wreq_rdy, o_wdata_rdy});
    end
    a0 = n_acc;
    repeat (3) tick();
    n_chk++;
    if (n_acc != a0) begin
      n_fail++;
      $display("FAIL reset_mid_abandon: %0d accesses after reset, required 0", n_acc - a0);
    end
    push_read(5'd12, 1, 6'd3);
    send_req(0, 5'd12, 1, 6'd3, fc, ok);
    wait_drain(dr);
    n_chk++;
    if (!(ok && dr)) begin
      n_fail++;
      $display("FAIL reset_mid_recover: fired=%b drained=%b, required 1 1", ok, dr);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_grant_order();
    test_read_stall();
    test_write_toggle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
